// File: rtl/mips_defs.sv
// Shared MIPS datapath constants: register file geometry, special register
// numbers and the text segment base used by trace checkers.
package mips_defs;
    localparam int          REG_W     = 32;
    localparam int          REG_N     = 32;
    localparam int          REG_AW    = 5;
    localparam logic [4:0]  REG_ZERO  = 5'd0;
    localparam logic [4:0]  REG_RA    = 5'd31;
    localparam logic [31:0] TEXT_BASE = 32'h0000_3000;
endpackage

// File: rtl/grf_rport.sv
// One combinational read port: forces $0 to zero and optionally forwards the
// in-flight write data when the addresses collide.
module grf_rport
    import mips_defs::*;
#(
    parameter bit BYPASS = 1'b0
) (
    input  logic [REG_AW-1:0] ra,
    input  logic [REG_W-1:0]  rdata,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [REG_W-1:0]  wd,
    output logic [REG_W-1:0]  rd
);
    always_comb begin
        rd = rdata;
        if (ra == REG_ZERO) begin
            rd = '0;
        end else if (BYPASS && we && (wa == ra)) begin
            rd = wd;
        end
    end
endmodule

// File: rtl/grf.sv
// 32x32 MIPS general register file: two combinational read ports, one
// synchronous write port, committed-write counter and per-commit trace.
module grf
    import mips_defs::*;
#(
    parameter bit BYPASS = 1'b0,
    parameter bit TRACE  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    input  logic [REG_AW-1:0] wa,
    input  logic [REG_W-1:0]  wd,
    input  logic [REG_W-1:0]  pc,
    output logic [REG_W-1:0]  rd1,
    output logic [REG_W-1:0]  rd2,
    output logic [REG_W-1:0]  wr_count
);
    logic [REG_N-1:0][REG_W-1:0] regs_q, regs_d;
    logic [REG_W-1:0]            wr_count_q, wr_count_d;
    logic                        commit;

    always_comb begin
        commit     = !reset && we && (wa != REG_ZERO);
        regs_d     = regs_q;
        wr_count_d = wr_count_q;
        if (reset) begin
            regs_d     = '0;
            wr_count_d = '0;
        end else if (commit) begin
            regs_d[wa] = wd;
            wr_count_d = wr_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        regs_q     <= regs_d;
        wr_count_q <= wr_count_d;
    end

    // Trace is simulation-only; synthesis drops the display.
    always @(posedge clk) begin
        if (TRACE && commit) begin
            $display("@%h: $%d <= %h", pc, wa, wd);
        end
    end

    grf_rport #(.BYPASS(BYPASS)) u_rport1 (
        .ra    (ra1),
        .rdata (regs_q[ra1]),
        .we    (we),
        .wa    (wa),
        .wd    (wd),
        .rd    (rd1)
    );

    grf_rport #(.BYPASS(BYPASS)) u_rport2 (
        .ra    (ra2),
        .rdata (regs_q[ra2]),
        .we    (we),
        .wa    (wa),
        .wd    (wd),
        .rd    (rd2)
    );

    assign wr_count = wr_count_q;
endmodule
